// File: rtl/idu_pipe.sv
// Registered RV32I decode stage: decodes ALU/branch/jump/upper-immediate ops, reads and
// forwards operands, and holds one decoded op behind a valid/ready handshake toward exu.
module idu_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [REG_AW-1:0]     rs1_addr_o,
    output logic [REG_AW-1:0]     rs2_addr_o,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  wb_en_i,
    input  logic [REG_AW-1:0]     wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  flush_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic [DATA_WIDTH-1:0] op1_o,
    output logic [DATA_WIDTH-1:0] op2_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [REG_AW-1:0]     rd_addr_o,
    output logic                  wen_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_AW-1:0]     rs1_f, rs2_f, rd_f;
    logic [DATA_WIDTH-1:0] imm_i, imm_b, imm_j, imm_u, pc_ext;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1_f  = REG_AW'(instr_i[19:15]);
    assign rs2_f  = REG_AW'(instr_i[24:20]);
    assign rd_f   = REG_AW'(instr_i[11:7]);
    assign pc_ext = DATA_WIDTH'(instr_addr_i);

    assign imm_i = DATA_WIDTH'($signed(instr_i[31:20]));
    assign imm_b = DATA_WIDTH'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
    assign imm_j = DATA_WIDTH'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
    assign imm_u = DATA_WIDTH'($signed({instr_i[31:12], 12'b0}));

    // x0 reads as zero; a same-cycle write-back overrides the regfile value.
    function automatic logic [DATA_WIDTH-1:0] read_op(
        input logic [REG_AW-1:0]     addr,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  wb_en,
        input logic [REG_AW-1:0]     wb_addr,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        if (addr == '0) return '0;
        if (wb_en && (wb_addr == addr)) return wb_data;
        return rf_data;
    endfunction

    assign rs1_val = read_op(rs1_f, rs1_data_i, wb_en_i, wb_addr_i, wb_data_i);
    assign rs2_val = read_op(rs2_f, rs2_data_i, wb_en_i, wb_addr_i, wb_data_i);

    logic                  legal, use_rs1, use_rs2, has_rd;
    logic [DATA_WIDTH-1:0] op1_d, op2_d, imm_d;
    logic [REG_AW-1:0]     rd_d;
    logic                  wen_d, illegal_d;

    always_comb begin
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        has_rd  = 1'b0;
        op1_d   = '0;
        op2_d   = '0;
        imm_d   = '0;
        unique case (opcode)
            OpcOpImm: begin
                if (funct3 == 3'b001) legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                op1_d   = rs1_val;
                op2_d   = imm_i;
                imm_d   = imm_i;
            end
            OpcOp: begin
                legal   = (funct7 == 7'h00) ||
                          ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                has_rd  = 1'b1;
                op1_d   = rs1_val;
                op2_d   = rs2_val;
            end
            OpcBranch: begin
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op1_d   = rs1_val;
                op2_d   = rs2_val;
                imm_d   = imm_b;
            end
            OpcJal: begin
                has_rd = 1'b1;
                op1_d  = pc_ext;
                op2_d  = DATA_WIDTH'(4);
                imm_d  = imm_j;
            end
            OpcJalr: begin
                legal   = (funct3 == 3'b000);
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                op1_d   = rs1_val;
                op2_d   = imm_i;
                imm_d   = imm_i;
            end
            OpcLui: begin
                has_rd = 1'b1;
                op2_d  = imm_u;
                imm_d  = imm_u;
            end
            OpcAuipc: begin
                has_rd = 1'b1;
                op1_d  = pc_ext;
                op2_d  = imm_u;
                imm_d  = imm_u;
            end
            default: legal = 1'b0;
        endcase
        // Illegal ops travel down the pipe as inert bubbles flagged for exu.
        if (!legal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            has_rd  = 1'b0;
            op1_d   = '0;
            op2_d   = '0;
            imm_d   = '0;
        end
        illegal_d = !legal;
        rd_d      = has_rd ? rd_f : '0;
        wen_d     = has_rd && (rd_f != '0);
    end

    assign rs1_addr_o = use_rs1 ? rs1_f : '0;
    assign rs2_addr_o = use_rs2 ? rs2_f : '0;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, op1_q, op2_q, imm_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [REG_AW-1:0]     rd_q;
    logic                  wen_q, illegal_q;
    logic                  hazard, load;

    // The held op's result is not forwardable until exu returns it on wb_*.
    assign hazard = valid_q && wen_q && (rd_q != '0) &&
                    ((use_rs1 && (rs1_f == rd_q)) || (use_rs2 && (rs2_f == rd_q)));

    assign in_ready = (!valid_q || out_ready) && !hazard && !flush_i;
    assign load     = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush_i)        valid_d = 1'b0;
        else if (load)      valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            addr_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                instr_q   <= instr_i;
                addr_q    <= instr_addr_i;
                op1_q     <= op1_d;
                op2_q     <= op2_d;
                imm_q     <= imm_d;
                rd_q      <= rd_d;
                wen_q     <= wen_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign instr_o      = instr_q;
    assign instr_addr_o = addr_q;
    assign op1_o        = op1_q;
    assign op2_o        = op2_q;
    assign imm_o        = imm_q;
    assign rd_addr_o    = rd_q;
    assign wen_o        = wen_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: hand-encoded RV32I words with hand-computed decode results.
module tb_idu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] instr_i;
    logic [9:0]  instr_addr_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic        out_valid, out_ready;
    logic [31:0] instr_o;
    logic [9:0]  instr_addr_o;
    logic [31:0] op1_o, op2_o, imm_o;
    logic [4:0]  rd_addr_o;
    logic        wen_o, illegal_o;

    int n_checks = 0;
    int n_pass   = 0;

    idu_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr_i      (instr_i),
        .instr_addr_i (instr_addr_i),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .wb_en_i      (wb_en_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .flush_i      (flush_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .imm_o        (imm_o),
        .rd_addr_o    (rd_addr_o),
        .wen_o        (wen_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Advance one edge; registered outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr_i = '0; instr_addr_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        flush_i = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_op1", op1_o, 32'd0);
        check("rst_wen", 32'(wen_o), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // add x3,x1,x2 with x1 forwarded from write-back
        in_valid = 1'b1; instr_i = 32'h002081B3; instr_addr_i = 10'h000;
        wb_en_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'd7;
        rs1_data_i = 32'd11; rs2_data_i = 32'd3;
        #1;
        check("add_in_ready", 32'(in_ready), 32'd1);
        check("add_rs1_addr", 32'(rs1_addr_o), 32'd1);
        check("add_rs2_addr", 32'(rs2_addr_o), 32'd2);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_op1_fwd", op1_o, 32'd7);
        check("add_op2", op2_o, 32'd3);
        check("add_rd", 32'(rd_addr_o), 32'd3);
        check("add_wen", 32'(wen_o), 32'd1);
        in_valid = 1'b0; wb_en_i = 1'b0; out_ready = 1'b1;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // addi x1,x0,5
        out_ready = 1'b0; in_valid = 1'b1; instr_i = 32'h00500093; instr_addr_i = 10'h004;
        #1;
        check("addi_rs1_addr", 32'(rs1_addr_o), 32'd0);
        check("addi_rs2_addr", 32'(rs2_addr_o), 32'd0);
        tick();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_op1", op1_o, 32'd0);
        check("addi_op2", op2_o, 32'd5);
        check("addi_imm", imm_o, 32'd5);
        check("addi_rd", 32'(rd_addr_o), 32'd1);
        check("addi_addr", 32'(instr_addr_o), 32'h004);

        // add x2,x1,x1 against held addi x1: RAW stall, then forward from wb
        instr_i = 32'h00108133; instr_addr_i = 10'h008; out_ready = 1'b1;
        rs1_data_i = 32'd99; rs2_data_i = 32'd99;
        #1;
        check("raw_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("raw_bubble_valid", 32'(out_valid), 32'd0);
        wb_en_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'd5;
        #1;
        check("raw_release", 32'(in_ready), 32'd1);
        tick();
        check("raw_valid", 32'(out_valid), 32'd1);
        check("raw_op1", op1_o, 32'd5);
        check("raw_op2", op2_o, 32'd5);
        check("raw_rd", 32'(rd_addr_o), 32'd2);

        // back-pressure: lui x5,0x12345 waits three cycles
        wb_en_i = 1'b0; out_ready = 1'b0; instr_i = 32'h123452B7; instr_addr_i = 10'h00C;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_instr_hold", instr_o, 32'h00108133);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("lui_instr", instr_o, 32'h123452B7);
        check("lui_op1", op1_o, 32'd0);
        check("lui_op2", op2_o, 32'h12345000);
        check("lui_rd", 32'(rd_addr_o), 32'd5);

        // jal x1,+8 at 0x010
        instr_i = 32'h008000EF; instr_addr_i = 10'h010;
        tick();
        check("jal_op1", op1_o, 32'h10);
        check("jal_op2", op2_o, 32'd4);
        check("jal_imm", imm_o, 32'd8);
        check("jal_wen", 32'(wen_o), 32'd1);

        // beq x3,x2,-4
        instr_i = 32'hFE218EE3; instr_addr_i = 10'h014;
        rs1_data_i = 32'h11; rs2_data_i = 32'h22;
        tick();
        check("beq_op1", op1_o, 32'h11);
        check("beq_op2", op2_o, 32'h22);
        check("beq_imm", imm_o, 32'hFFFFFFFC);
        check("beq_rd", 32'(rd_addr_o), 32'd0);
        check("beq_wen", 32'(wen_o), 32'd0);

        // all-ones word is illegal
        instr_i = 32'hFFFFFFFF;
        #1;
        check("ill_rs1_addr", 32'(rs1_addr_o), 32'd0);
        tick();
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_flag", 32'(illegal_o), 32'd1);
        check("ill_wen", 32'(wen_o), 32'd0);
        check("ill_rd", 32'(rd_addr_o), 32'd0);
        check("ill_op1", op1_o, 32'd0);

        // funct7=0x01 (M-extension mul) is illegal here; sub is legal
        instr_i = 32'h02208133;
        tick();
        check("mul_illegal", 32'(illegal_o), 32'd1);
        instr_i = 32'h40208233;
        tick();
        check("sub_illegal", 32'(illegal_o), 32'd0);
        check("sub_op1", op1_o, 32'h11);
        check("sub_rd", 32'(rd_addr_o), 32'd4);

        // flush beats load
        out_ready = 1'b0; flush_i = 1'b1; instr_i = 32'h00500093;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush_i = 1'b0;
        tick();
        check("post_flush_load", 32'(out_valid), 32'd1);

        // reset drops the held op and clears outputs
        rst = 1'b1;
        tick();
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_instr", instr_o, 32'd0);
        check("rst2_op2", op2_o, 32'd0);
        check("rst2_rd", 32'(rd_addr_o), 32'd0);
        check("rst2_wen", 32'(wen_o), 32'd0);
        rst = 1'b0; in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
